// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter: round-robin owner of the SDRAM command path shared by   |
// | the Wishbone ports and refresh, with a dead gap between owners. Rev 1.0  |
// +--------------------------------------------------------------------------+
module wb_port_arbiter #(
    parameter int NR_PORTS   = 3,
    parameter int IDX_W      = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic [NR_PORTS-1:0] req_i,
    input  logic                refresh_req_i,
    input  logic                refresh_done_i,
    output logic [NR_PORTS-1:0] gnt_o,
    output logic                gnt_valid_o,
    output logic [IDX_W-1:0]    gnt_idx_o,
    output logic                refresh_gnt_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PORT    = 2'd1,
        ST_REFRESH = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    localparam logic [2:0]       C_GAP_LOAD  = 3'(GAP_CYCLES);
    localparam logic [IDX_W-1:0] C_PTR_RST   = IDX_W'(NR_PORTS - 1);
    localparam state_t           C_REL_STATE = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t              state_q, state_d;
    logic [NR_PORTS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                refresh_gnt_q, refresh_gnt_d;
    logic                busy_q, busy_d;
    logic [2:0]          gap_cnt_q, gap_cnt_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;

    // Scan upward from the port after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NR_PORTS; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NR_PORTS);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        idx_d         = idx_q;
        ptr_d         = ptr_q;
        refresh_gnt_d = refresh_gnt_q;
        gap_cnt_d     = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (refresh_req_i) begin
                    state_d       = ST_REFRESH;
                    refresh_gnt_d = 1'b1;
                end else if (win_found) begin
                    state_d        = ST_PORT;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    idx_d          = win_idx;
                    ptr_d          = win_idx;
                end
            end
            ST_PORT: begin
                // No preemption: only the owner's own request matters here.
                if (!req_i[idx_q]) begin
                    state_d   = C_REL_STATE;
                    gnt_d     = '0;
                    gap_cnt_d = C_GAP_LOAD;
                end
            end
            ST_REFRESH: begin
                if (refresh_done_i) begin
                    state_d       = C_REL_STATE;
                    refresh_gnt_d = 1'b0;
                    gap_cnt_d     = C_GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= 3'd1) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            idx_q         <= '0;
            ptr_q         <= C_PTR_RST;
            refresh_gnt_q <= 1'b0;
            busy_q        <= 1'b0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            idx_q         <= idx_d;
            ptr_q         <= ptr_d;
            refresh_gnt_q <= refresh_gnt_d;
            busy_q        <= busy_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign gnt_valid_o   = |gnt_q;
    assign gnt_idx_o     = idx_q;
    assign refresh_gnt_o = refresh_gnt_q;
    assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_port_arbiter: bench for wb_port_arbiter, one build with a 1-cycle  |
// | gap (a) and one with no gap (b). Rev 1.0                                 |
// +--------------------------------------------------------------------------+
module tb_wb_port_arbiter;

    localparam int C_N    = 3;
    localparam int C_NONE = -1;
    localparam int C_REF  = C_N;

    logic       clk;
    logic       rst;
    logic [2:0] r_req_a, r_req_b;
    logic       r_rf_a, r_rf_b, r_dn_a, r_dn_b;
    logic [2:0] w_gnt_a, w_gnt_b;
    logic       w_val_a, w_val_b;
    logic [1:0] w_idx_a, w_idx_b;
    logic       w_rg_a, w_rg_b, w_busy_a, w_busy_b;

    int n_cmp = 0;
    int n_err = 0;

    // Abstract model: who owns the path, how many cooldown cycles remain,
    // last port winner (reported index) and round-robin reference.
    int m_owner [2];
    int m_cool  [2];
    int m_last  [2];
    int m_rr    [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter #(.NR_PORTS(3), .IDX_W(2), .GAP_CYCLES(1)) dut (
        .wb_clk(clk), .wb_rst(rst), .req_i(r_req_a), .refresh_req_i(r_rf_a),
        .refresh_done_i(r_dn_a), .gnt_o(w_gnt_a), .gnt_valid_o(w_val_a),
        .gnt_idx_o(w_idx_a), .refresh_gnt_o(w_rg_a), .busy_o(w_busy_a)
    );

    wb_port_arbiter #(.NR_PORTS(3), .IDX_W(2), .GAP_CYCLES(0)) dut0 (
        .wb_clk(clk), .wb_rst(rst), .req_i(r_req_b), .refresh_req_i(r_rf_b),
        .refresh_done_i(r_dn_b), .gnt_o(w_gnt_b), .gnt_valid_o(w_val_b),
        .gnt_idx_o(w_idx_b), .refresh_gnt_o(w_rg_b), .busy_o(w_busy_b)
    );

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = C_NONE;
            m_cool[d]  = 0;
            m_last[d]  = 0;
            m_rr[d]    = C_N - 1;
        end
    endtask

    task automatic model_step(input int d, input int gap, input logic [2:0] rq,
                              input logic rfr, input logic dn);
        bit found;
        int p;
        found = 1'b0;
        if (m_owner[d] == C_REF) begin
            if (dn) begin
                m_owner[d] = C_NONE;
                m_cool[d]  = gap;
            end
        end else if (m_owner[d] != C_NONE) begin
            if (!rq[m_owner[d]]) begin
                m_owner[d] = C_NONE;
                m_cool[d]  = gap;
            end
        end else if (m_cool[d] > 0) begin
            m_cool[d] = m_cool[d] - 1;
        end else if (rfr) begin
            m_owner[d] = C_REF;
        end else begin
            for (int k = 1; k <= C_N; k++) begin
                p = (m_rr[d] + k) % C_N;
                if (!found && rq[p]) begin
                    found      = 1'b1;
                    m_owner[d] = p;
                    m_last[d]  = p;
                    m_rr[d]    = p;
                end
            end
        end
    endtask

    // {gnt[2:0], gnt_valid, gnt_idx[1:0], refresh_gnt, busy}
    function automatic logic [7:0] model_out(input int d);
        logic [2:0] g;
        logic       is_port;
        g       = 3'b000;
        is_port = (m_owner[d] >= 0) && (m_owner[d] < C_N);
        if (is_port) g[m_owner[d]] = 1'b1;
        return {g, is_port, 2'(m_last[d]), (m_owner[d] == C_REF),
                (m_owner[d] != C_NONE) || (m_cool[d] > 0)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, 1, r_req_a, r_rf_a, r_dn_a);
            model_step(1, 0, r_req_b, r_rf_b, r_dn_b);
        end
    end

    task automatic cmp_model(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s t=%0t: got gnt=%b val=%b idx=%0d rg=%b busy=%b, want gnt=%b val=%b idx=%0d rg=%b busy=%b",
                     name, $time, act[7:5], act[4], act[3:2], act[1], act[0],
                     exp[7:5], exp[4], exp[3:2], exp[1], exp[0]);
        end
        n_cmp = n_cmp + 1;
        if (!$onehot0(act[7:5]) || ((act[7:5] != 3'b000) && act[1])) begin
            n_err = n_err + 1;
            $display("FAIL %s_excl t=%0t: got gnt=%b rg=%b, want one-hot-or-zero and exclusive",
                     name, $time, act[7:5], act[1]);
        end
    endtask

    always @(negedge clk) begin
        cmp_model("model_a", {w_gnt_a, w_val_a, w_idx_a, w_rg_a, w_busy_a}, model_out(0));
        cmp_model("model_b", {w_gnt_b, w_val_b, w_idx_b, w_rg_b, w_busy_b}, model_out(1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s t=%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int order [4];
    int waited;

    initial begin
        rst = 1'b1;
        r_req_a = '0; r_rf_a = 1'b0; r_dn_a = 1'b0;
        r_req_b = '0; r_rf_b = 1'b0; r_dn_b = 1'b0;
        tick(2);
        check("rst_gnt",  {29'd0, w_gnt_a}, 32'h0);
        check("rst_idx",  {30'd0, w_idx_a}, 32'h0);
        check("rst_busy", {31'd0, w_busy_a}, 32'h0);
        check("rst_rg",   {31'd0, w_rg_a}, 32'h0);
        #2 rst = 1'b0;
        tick(1);

        // Round robin with each owner dropping 4 cycles after its grant.
        r_req_a = 3'b111;
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            do begin
                tick(1);
                waited++;
            end while (!w_val_a && waited < 20);
            order[g] = int'(w_idx_a);
            check("rr_wait", waited, (g == 0) ? 1 : 2);
            if (g < 3) begin
                tick(4);
                r_req_a[w_idx_a] = 1'b0;
                tick(1);
                r_req_a = 3'b111;
            end else begin
                tick(1);
                r_req_a = 3'b000;
                tick(3);
            end
        end
        check("rr_order0", order[0], 0);
        check("rr_order1", order[1], 1);
        check("rr_order2", order[2], 2);
        check("rr_order3", order[3], 0);

        // Hold: no preemption by port 0 or refresh.
        r_req_a = 3'b010;
        tick(1);
        check("hold_first", {29'd0, w_gnt_a}, 32'h2);
        r_req_a = 3'b011;
        r_rf_a  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("hold_gnt", {29'd0, w_gnt_a}, 32'h2);
        end
        r_req_a = 3'b001;
        tick(1);
        check("hold_rel_gnt", {29'd0, w_gnt_a}, 32'h0);
        tick(1);
        check("hold_idle_busy", {31'd0, w_busy_a}, 32'h0);
        tick(1);
        check("hold_ref_first", {31'd0, w_rg_a}, 32'h1);
        check("hold_ref_nogn", {29'd0, w_gnt_a}, 32'h0);
        tick(3);
        r_dn_a = 1'b1;
        r_rf_a = 1'b0;
        tick(1);
        r_dn_a = 1'b0;
        check("ref_done_rg", {31'd0, w_rg_a}, 32'h0);
        check("ref_done_busy", {31'd0, w_busy_a}, 32'h1);
        tick(2);
        check("after_ref_p0", {29'd0, w_gnt_a}, 32'h1);

        // Spurious done while a port owns the path.
        r_dn_a = 1'b1;
        tick(1);
        r_dn_a = 1'b0;
        check("spur_gnt", {29'd0, w_gnt_a}, 32'h1);
        tick(2);
        check("spur_gnt2", {29'd0, w_gnt_a}, 32'h1);
        r_req_a = 3'b000;
        tick(3);

        // Refresh and port 2 rise together from IDLE.
        r_rf_a  = 1'b1;
        r_req_a = 3'b100;
        tick(1);
        check("pri_rg", {31'd0, w_rg_a}, 32'h1);
        check("pri_gnt", {29'd0, w_gnt_a}, 32'h0);
        tick(7);
        r_dn_a = 1'b1;
        r_rf_a = 1'b0;
        tick(1);
        r_dn_a = 1'b0;
        check("pri_done_rg", {31'd0, w_rg_a}, 32'h0);
        tick(1);
        check("pri_gap_gnt", {29'd0, w_gnt_a}, 32'h0);
        tick(1);
        check("pri_p2_gnt", {29'd0, w_gnt_a}, 32'h4);
        check("pri_p2_idx", {30'd0, w_idx_a}, 32'h2);
        r_req_a = 3'b000;
        tick(3);

        // Zero-gap build: handover two cycles after the owner drops.
        r_req_b = 3'b001;
        tick(1);
        check("g0_first", {29'd0, w_gnt_b}, 32'h1);
        tick(2);
        r_req_b = 3'b100;
        tick(1);
        check("g0_rel", {29'd0, w_gnt_b}, 32'h0);
        tick(1);
        check("g0_p2", {29'd0, w_gnt_b}, 32'h4);
        check("g0_p2_idx", {30'd0, w_idx_b}, 32'h2);
        r_req_b = 3'b000;
        tick(2);

        // Asynchronous reset in the middle of a port grant.
        r_req_a = 3'b010;
        tick(1);
        check("ar_pre_gnt", {29'd0, w_gnt_a}, 32'h2);
        #2 rst = 1'b1;
        #1;
        check("ar_gnt",  {29'd0, w_gnt_a}, 32'h0);
        check("ar_rg",   {31'd0, w_rg_a}, 32'h0);
        check("ar_busy", {31'd0, w_busy_a}, 32'h0);
        check("ar_idx",  {30'd0, w_idx_a}, 32'h0);
        tick(1);
        #2 rst = 1'b0;
        r_req_a = 3'b111;
        tick(1);
        check("ar_post_gnt", {29'd0, w_gnt_a}, 32'h1);
        check("ar_post_idx", {30'd0, w_idx_a}, 32'h0);
        r_req_a = 3'b000;
        tick(3);

        // Random traffic, same stimulus to both builds.
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 5) == 0) r_req_a[b] = ~r_req_a[b];
            if ($urandom_range(0, 11) == 0) r_rf_a = ~r_rf_a;
            r_dn_a  = ($urandom_range(0, 5) == 0);
            r_req_b = r_req_a;
            r_rf_b  = r_rf_a;
            r_dn_b  = r_dn_a;
            tick(1);
        end
        r_req_a = '0; r_rf_a = 1'b0; r_dn_a = 1'b0;
        r_req_b = '0; r_rf_b = 1'b0; r_dn_b = 1'b0;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Round-robin arbiter that shares the single SDRAM command path of the memory controller between the Wishbone slave ports (wbs0, wbs1, wbs4) and the periodic refresh request. It grants exactly one owner at a time and holds the grant for the owner's whole bus cycle. It inserts a programmable dead gap between owners so the SDRAM pipeline can drain. It sits between the per-port Wishbone front ends and the SDRAM command FSM, in the wb_clk domain.

Parameters:
NR_PORTS, 3, number of Wishbone requesters (port i maps to request bit i).
IDX_W, 2, width of the encoded grant index; must satisfy 2**IDX_W >= NR_PORTS.
GAP_CYCLES, 1, idle cycles inserted after any release before the next grant; range 0..7.

Ports:
wb_clk  in  1  clock
wb_rst  in  1  asynchronous active-high reset
req_i  in  NR_PORTS  per-port request, equal to cyc_i & stb_i of that port
refresh_req_i  in  1  refresh timer request, level, held until serviced
refresh_done_i  in  1  single-cycle pulse from the SDRAM FSM when the refresh sequence completes
gnt_o  out  NR_PORTS  one-hot port grant, registered
gnt_valid_o  out  1  a port grant is active (OR of gnt_o)
gnt_idx_o  out  IDX_W  binary index of the granted port; holds last value when no grant
refresh_gnt_o  out  1  refresh owns the command path, registered
busy_o  out  1  any grant active or gap in progress

Behaviour:
- Reset (async, wb_rst=1): state=IDLE, gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, refresh_gnt_o=0, busy_o=0, RR pointer=NR_PORTS-1 (port 0 wins first), gap counter=0.
- Reset asserted mid-grant drops all grants immediately, without waiting for the owner's cycle to end.
- Single FSM with four states: IDLE, PORT, REFRESH, GAP.
- IDLE, refresh_req_i=1: go to REFRESH and set refresh_gnt_o next cycle. Refresh has priority over all ports.
- IDLE, no refresh and any req_i bit set: go to PORT. Winner is the first set bit scanning upward from RR pointer+1, wrapping modulo NR_PORTS. gnt_o, gnt_idx_o and gnt_valid_o are registered and valid on the next edge (latency 1 clock from req to gnt). RR pointer is set to the winner.
- PORT: grant held while req_i[gnt_idx_o]=1. Other requests and refresh_req_i are ignored; there is no preemption.
  - When req_i[gnt_idx_o]=0, gnt_o clears on the next edge.
  - Then go to GAP if GAP_CYCLES>0, else to IDLE.
- REFRESH: refresh_gnt_o held until refresh_done_i=1. It clears on the next edge, then GAP or IDLE as above. refresh_done_i outside REFRESH is ignored.
- GAP: counter loads GAP_CYCLES on entry and decrements each cycle. Exit to IDLE when it reaches 1. No grant is issued in GAP.
- With GAP_CYCLES=0, a new grant can follow a release after one IDLE cycle.
- Simultaneous events:
  - Refresh and port request in the same IDLE cycle: refresh wins, and the port waits.
  - Owner drops req_i in the same cycle another requests: the owner is released and the other is arbitrated from IDLE.
  - A port that drops and re-raises its request is placed behind all pending ports by RR order.
- Invariant: gnt_o is one-hot or zero. gnt_o and refresh_gnt_o are never both nonzero.
- busy_o = (state != IDLE), registered.
- gnt_idx_o is unchanged when gnt_valid_o=0.

Test Plan:
- Reset: assert wb_rst asynchronously mid-clock during a PORT grant → gnt_o=000, refresh_gnt_o=0, busy_o=0 immediately. After release, req_i=111 → gnt_o=001, gnt_idx_o=0 one cycle later.
- Round-robin: req_i held at 111, each owner drops its request 4 cycles after its grant, GAP_CYCLES=1 → grant order 0,1,2,0. Exactly 1 gap cycle plus 1 IDLE cycle between consecutive grants.
- Hold: port 1 granted while port 0 and refresh_req_i assert → gnt_o stays 010 for all 20 cycles port 1 holds its request. Refresh is granted before port 0 after release.
- Refresh priority: refresh_req_i and req_i=100 rise in the same cycle from IDLE → refresh_gnt_o=1 next cycle. Pulse refresh_done_i after 8 cycles → refresh_gnt_o=0, then gnt_o=100 after gap + 1.
- Spurious done: refresh_done_i pulsed while gnt_o=001 → no state change, grant held.
- GAP_CYCLES=0 build: port 0 releases while port 2 requests → gnt_o=100 two cycles after port 0's request falls. One-hot and mutual-exclusion assertions hold throughout 10k cycles of random req_i/refresh traffic.
